// File: rtl/sa_output_drain.sv
// sa_output_drain: buffers systolic-array output vectors in a small FIFO,
// then requantizes and streams one lane per beat over valid/ready.
module sa_output_drain #(
   parameter int ARRAY_LENGTH = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          res,
   input  logic [ARRAY_LENGTH*32-1:0]    SoutL,
   input  logic                          Sready,
   input  logic [4:0]                    shift,
   input  logic                          relu,
   input  logic                          width,
   output logic [15:0]                   Dout,
   output logic                          Dvalid,
   input  logic                          Dready,
   output logic                          Dlast,
   output logic [$clog2(FIFO_DEPTH):0]   Fcount,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = (ARRAY_LENGTH > 1) ? $clog2(ARRAY_LENGTH) : 1;
   localparam int VW = ARRAY_LENGTH * 32;
   localparam int EW = VW + 7;
   localparam logic [LW-1:0] LAST = LW'(ARRAY_LENGTH - 1);
   localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;

   // 34-bit intermediate keeps the rounding add from overflowing
   function automatic logic [15:0] requant(input logic [31:0] x, input logic [4:0] sh,
                                           input logic rl, input logic wd);
      logic signed [33:0] t;
      logic signed [33:0] rnd;
      logic [15:0]        r;
      t   = {{2{x[31]}}, x};
      rnd = '0;
      if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
      t = (t + rnd) >>> sh;
      if (rl && t[33]) t = '0;
      if (wd) begin
         if (t > 34'sd32767)       r = 16'h7FFF;
         else if (t < -34'sd32768) r = 16'h8000;
         else                      r = t[15:0];
      end else begin
         if (t > 34'sd127)         r = 16'h007F;
         else if (t < -34'sd128)   r = 16'hFF80;
         else                      r = {{8{t[7]}}, t[7:0]};
      end
      return r;
   endfunction

   function automatic logic [31:0] lane_of(input logic [VW-1:0] v, input logic [LW-1:0] i);
      return v[32*i +: 32];
   endfunction

   // FIFO storage and pointers
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          ovf_q;

   // serializer state
   state_t        state_q;
   logic [LW-1:0] lane_q;
   logic [VW-1:0] vec_q;
   logic [4:0]    sh_q;
   logic          rl_q, wd_q;
   logic [15:0]   dout_q;
   logic          dvalid_q, dlast_q;

   logic [EW-1:0] head;
   logic [VW-1:0] head_vec;
   logic          empty, full, push, pop, drop;
   logic [LW-1:0] nxt_lane;

   assign head     = mem_q[rd_q];
   assign head_vec = head[EW-1:7];
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == FULL);
   assign nxt_lane = lane_q + 1'b1;
   // a pop happens when idle, or on the last-lane handshake (no bubble)
   assign pop  = !empty && ((state_q == S_IDLE) ||
                 (state_q == S_STREAM && Dready && lane_q == LAST));
   assign push = Sready && (!full || pop);
   assign drop = Sready && full && !pop;

   // entry write: data plus the config latched for this vector
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {SoutL, shift, relu, width};
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (res) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (drop) ovf_q <= 1'b1;
      end
   end

   // serializer FSM with registered Dout/Dvalid/Dlast
   always_ff @(posedge clk) begin
      if (res) begin
         state_q  <= S_IDLE;
         lane_q   <= '0;
         vec_q    <= '0;
         sh_q     <= '0;
         rl_q     <= 1'b0;
         wd_q     <= 1'b0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         dlast_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  vec_q   <= head_vec;
                  sh_q    <= head[6:2];
                  rl_q    <= head[1];
                  wd_q    <= head[0];
                  state_q <= S_PRIME;
               end
            end
            S_PRIME: begin
               dout_q   <= requant(lane_of(vec_q, '0), sh_q, rl_q, wd_q);
               dvalid_q <= 1'b1;
               dlast_q  <= (LAST == '0);
               lane_q   <= '0;
               state_q  <= S_STREAM;
            end
            S_STREAM: begin
               if (Dready) begin
                  if (lane_q == LAST) begin
                     if (!empty) begin
                        vec_q   <= head_vec;
                        sh_q    <= head[6:2];
                        rl_q    <= head[1];
                        wd_q    <= head[0];
                        dout_q  <= requant(lane_of(head_vec, '0), head[6:2], head[1], head[0]);
                        dlast_q <= (LAST == '0);
                        lane_q  <= '0;
                     end else begin
                        dvalid_q <= 1'b0;
                        dlast_q  <= 1'b0;
                        state_q  <= S_IDLE;
                     end
                  end else begin
                     dout_q  <= requant(lane_of(vec_q, nxt_lane), sh_q, rl_q, wd_q);
                     dlast_q <= (nxt_lane == LAST);
                     lane_q  <= nxt_lane;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Dout     = dout_q;
   assign Dvalid   = dvalid_q;
   assign Dlast    = dlast_q;
   assign Fcount   = cnt_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_sa_output_drain.sv
// Bench for sa_output_drain: scoreboard of expected beats plus per-scenario tasks.
module tb_sa_output_drain;

   localparam int L = 4;
   localparam int D = 4;

   logic            clk = 1'b0;
   logic            res;
   logic [L*32-1:0] SoutL;
   logic            Sready;
   logic [4:0]      shift;
   logic            relu;
   logic            width;
   logic [15:0]     Dout;
   logic            Dvalid;
   logic            Dready;
   logic            Dlast;
   logic [$clog2(D):0] Fcount;
   logic            overflow;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int hs_cnt    = 0;
   logic [16:0] sb [$];   // {Dout, Dlast}

   logic        stall_prev = 1'b0;
   logic [15:0] hold_dout;
   logic        hold_last;

   sa_output_drain #(.ARRAY_LENGTH(L), .FIFO_DEPTH(D)) dut (
      .clk(clk), .res(res), .SoutL(SoutL), .Sready(Sready), .shift(shift),
      .relu(relu), .width(width), .Dout(Dout), .Dvalid(Dvalid), .Dready(Dready),
      .Dlast(Dlast), .Fcount(Fcount), .overflow(overflow));

   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic signed [31:0] x, input int sh,
                                         input bit rl, input bit wd);
      longint v;
      v = x;
      if (sh > 0) v = (v + (64'sd1 <<< (sh - 1))) >>> sh;
      if (rl && v < 0) v = 0;
      if (wd) begin
         if (v > 32767) v = 32767;
         if (v < -32768) v = -32768;
      end else begin
         if (v > 127) v = 127;
         if (v < -128) v = -128;
      end
      return 16'(v);
   endfunction

   function automatic logic [L*32-1:0] pack4(input int a, input int b, input int c, input int d);
      return {d[31:0], c[31:0], b[31:0], a[31:0]};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one Sready pulse; expected beats queued only if the vector will be kept
   task automatic pulse(input logic [L*32-1:0] v, input int sh, input bit rl, input bit wd,
                        input bit keep);
      SoutL = v; shift = 5'(sh); relu = rl; width = wd; Sready = 1'b1;
      if (keep)
         for (int i = 0; i < L; i++)
            sb.push_back({model(v[i*32 +: 32], sh, rl, wd), (i == L - 1)});
      cyc(1);
      Sready = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (!(sb.size() == 0 && !Dvalid) && n < 300) begin
         cyc(1);
         n++;
      end
      total_cnt++;
      if (sb.size() != 0 || Dvalid)
         $display("FAIL %s drain: %0d beats outstanding, Dvalid=%b, want 0/0", name, sb.size(), Dvalid);
      else pass_cnt++;
   endtask

   // handshake monitor: scoreboard compare and stall-hold check
   always @(negedge clk) begin
      if (res) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            total_cnt++;
            if (Dvalid !== 1'b1 || Dout !== hold_dout || Dlast !== hold_last)
               $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        Dvalid, Dout, Dlast, hold_dout, hold_last);
            else pass_cnt++;
         end
         if (Dvalid === 1'b1 && Dready === 1'b1) begin
            logic [16:0] e;
            hs_cnt++;
            total_cnt++;
            if (sb.size() == 0) begin
               $display("FAIL beat: unexpected beat d=%h l=%b, want none", Dout, Dlast);
            end else begin
               e = sb.pop_front();
               if ({Dout, Dlast} !== e)
                  $display("FAIL beat: got d=%h l=%b want d=%h l=%b", Dout, Dlast, e[16:1], e[0]);
               else pass_cnt++;
            end
         end
         stall_prev = (Dvalid === 1'b1) && (Dready === 1'b0);
         hold_dout  = Dout;
         hold_last  = Dlast;
      end
   end

   task automatic test_reset;
      res = 1'b1; Sready = 1'b0; Dready = 1'b0;
      SoutL = '0; shift = '0; relu = 1'b0; width = 1'b0;
      cyc(2);
      res = 1'b0;
      sb.delete();
      total_cnt++;
      if ({Dout, Dvalid, Dlast, Fcount, overflow} !== '0)
         $display("FAIL reset: got d=%h v=%b l=%b f=%0d o=%b want all 0",
                  Dout, Dvalid, Dlast, Fcount, overflow);
      else pass_cnt++;
   endtask

   task automatic test_single;
      Dready = 1'b1;
      pulse(pack4(100, -100, 70000, -70000), 0, 0, 1, 1);
      total_cnt++;
      if (Dvalid !== 1'b0 || Fcount !== 3'd1)
         $display("FAIL lat_e0: got v=%b f=%0d want v=0 f=1", Dvalid, Fcount);
      else pass_cnt++;
      cyc(1);
      total_cnt++;
      if (Dvalid !== 1'b0) $display("FAIL lat_e1: got v=%b want 0", Dvalid);
      else pass_cnt++;
      cyc(1);
      total_cnt++;
      if (Dvalid !== 1'b1 || Dout !== 16'h0064 || Dlast !== 1'b0)
         $display("FAIL lat_e2: got v=%b d=%h l=%b want v=1 d=0064 l=0", Dvalid, Dout, Dlast);
      else pass_cnt++;
      wait_empty("single");
   endtask

   task automatic test_round_relu;
      Dready = 1'b1;
      pulse(pack4(5, 6, -5, -6), 2, 0, 0, 1);
      pulse(pack4(5, 6, -5, -6), 2, 1, 0, 1);
      pulse(pack4(32'h7FFFFFFF, -1, 300, -300), 1, 0, 0, 1);
      wait_empty("round_relu");
   endtask

   task automatic test_backpressure;
      int h0, n;
      bit pat [4] = '{1, 0, 0, 1};
      h0 = hs_cnt;
      Dready = 1'b0;
      pulse(pack4(1000, -1000, 65536, -1), 4, 1, 1, 1);
      pulse(pack4(-123456, 777, 31, -129), 3, 0, 1, 1);
      n = 0;
      while (!(sb.size() == 0 && !Dvalid) && n < 300) begin
         Dready = pat[n % 4];
         cyc(1);
         n++;
      end
      Dready = 1'b1;
      total_cnt++;
      if (hs_cnt - h0 != 2 * L || sb.size() != 0)
         $display("FAIL bp_count: got %0d handshakes, %0d left want %0d, 0", hs_cnt - h0, sb.size(), 2 * L);
      else pass_cnt++;
   endtask

   task automatic test_fill_overflow;
      Dready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         pulse(pack4(k * 10, -k * 300, k * 1000, k), k % 3, k[0], k[1], k <= 5);
         if (k == 5) begin
            total_cnt++;
            if (Fcount !== 3'd4 || overflow !== 1'b0)
               $display("FAIL fill5: got f=%0d o=%b want f=4 o=0", Fcount, overflow);
            else pass_cnt++;
         end
         if (k == 6) begin
            total_cnt++;
            if (Fcount !== 3'd4 || overflow !== 1'b1)
               $display("FAIL fill6: got f=%0d o=%b want f=4 o=1", Fcount, overflow);
            else pass_cnt++;
         end
         cyc(2);
      end
      Dready = 1'b1;
      wait_empty("fill");
      total_cnt++;
      if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
      else pass_cnt++;
   endtask

   task automatic test_full_pop;
      bit done;
      Dready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         pulse(pack4(k, -k, k * 50, -k * 50), 1, 0, 0, 1);
         cyc(2);
      end
      Dready = 1'b1;
      done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
         if (Dvalid && Dlast) begin
            pulse(pack4(9999, -9999, 42, -42), 0, 0, 1, 1);
            done = 1;
            total_cnt++;
            if (Fcount !== 3'd4 || overflow !== 1'b0)
               $display("FAIL full_pop: got f=%0d o=%b want f=4 o=0", Fcount, overflow);
            else pass_cnt++;
         end else cyc(1);
      end
      total_cnt++;
      if (!done) $display("FAIL full_pop_seen: got no last beat want one");
      else pass_cnt++;
      wait_empty("full_pop");
   endtask

   task automatic test_reset_mid;
      bit quiet;
      Dready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         pulse(pack4(k * 7, k * 8, k * 9, k * 11), 0, 0, 1, 1);
         cyc(2);
      end
      Dready = 1'b1;
      cyc(2);   // lanes 0 and 1 accepted, lane 2 presented
      res = 1'b1; Dready = 1'b0;
      cyc(1);
      res = 1'b0;
      sb.delete();
      total_cnt++;
      if (Dvalid !== 1'b0 || Fcount !== 3'd0 || overflow !== 1'b0)
         $display("FAIL rst_mid: got v=%b f=%0d o=%b want 0/0/0", Dvalid, Fcount, overflow);
      else pass_cnt++;
      Dready = 1'b1;
      quiet = 1;
      for (int n = 0; n < 6; n++) begin
         cyc(1);
         if (Dvalid !== 1'b0) quiet = 0;
      end
      total_cnt++;
      if (!quiet) $display("FAIL rst_quiet: got Dvalid=1 after reset want 0");
      else pass_cnt++;
      pulse(pack4(-1, 128, -129, 40000), 0, 0, 0, 1);
      wait_empty("post_reset");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_relu();
      test_backpressure();
      test_fill_overflow();
      test_reset();
      test_full_pop();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sa_output_drain.md
Name: sa_output_drain

Overview:
Downstream stage of the systolic array. Captures each completed output vector (one 32-bit signed accumulator per array column) on the array's ready pulse and buffers it in a vector FIFO. It then requantizes each lane (round, shift, optional ReLU, saturate to 8 or 16 bits) and streams lanes out one per beat over a valid/ready interface toward the DMA/AXI-stream writer.

Parameters:
ARRAY_LENGTH, 4, number of array columns (lanes per vector); must match the array instance
FIFO_DEPTH, 4, vector entries buffered; power of two, at least 2

Ports:
clk  in  1  clock; all logic on posedge
res  in  1  synchronous active-high reset
SoutL  in  ARRAY_LENGTH*32  packed array outputs; lane i = SoutL[i*32+31:i*32], two's complement
Sready  in  1  one-cycle pulse; SoutL valid in the same cycle
shift  in  5  arithmetic right-shift amount, 0..31
relu  in  1  1 = clamp negatives to 0
width  in  1  0 = saturate to signed 8-bit, 1 = saturate to signed 16-bit
Dout  out  16  requantized lane; 8-bit results sign-extended to 16
Dvalid  out  1  Dout valid
Dready  in  1  downstream accepts when Dvalid and Dready are both high
Dlast  out  1  high with the last lane (ARRAY_LENGTH-1) of a vector
Fcount  out  $clog2(FIFO_DEPTH)+1  vectors held in the FIFO (excludes the vector in the serializer)
overflow  out  1  sticky; set when a Sready vector is dropped

Behaviour:
- Reset: clk and res are the only clock and reset. Synchronous active-high reset, applied at the next posedge. Clears the FIFO pointers, the serializer and the lane counter. All outputs become 0 (Dout, Dvalid, Dlast, Fcount, overflow). Reset mid-stream discards all buffered and in-flight data, with no partial beats after reset.
- Capture: on a posedge with Sready=1 and room in the FIFO, write {SoutL, shift, relu, width} as one entry. Config is latched per vector; later config changes do not affect vectors already captured.
- Room: FIFO not full, or full with a pop in the same cycle. Capture and pop in the same cycle leaves Fcount unchanged.
- Drop: Sready=1 with a full FIFO and no pop drops the vector and sets overflow. overflow clears only on reset.
- Serializer states:
  - IDLE: Dvalid=0. Loads the FIFO head when the FIFO is non-empty (a pop), then moves to STREAM with lane counter = 0.
  - STREAM: presents lane[counter]; Dvalid=1. On a handshake, counter increments.
  - On a handshake at counter = ARRAY_LENGTH-1:
    - If the FIFO is non-empty, load the next entry in the same cycle (no bubble) and reset counter to 0.
    - Otherwise go to IDLE.
- Dout, Dlast and Dvalid are registered. They are held stable while Dvalid=1 and Dready=0.
- Lane order: lane 0 first. Dlast=1 exactly when counter = ARRAY_LENGTH-1 and Dvalid=1.
- Latency: Sready at posedge E0 with FIFO empty and serializer IDLE gives Dvalid=1 after posedge E2 (2 cycles). Throughput is 1 lane per cycle with Dready held high.
- Requant per lane x (32-bit signed):
  1. Extend x to 34-bit signed.
  2. If shift>0, add 1<<(shift-1) (round half up), then arithmetic right shift by shift.
  3. If relu=1 and the result is negative, the result becomes 0.
  4. Saturate to [-128, 127] (width=0) or [-32768, 32767] (width=1).
- Requant rounding cannot overflow thanks to the 34-bit intermediate (0x7FFFFFFF with shift=1 gives 0x40000000, then saturates).
- Fcount increments on a capture, decrements on a pop, and is unchanged when both happen. It never exceeds FIFO_DEPTH.

Test Plan:
- Single vector, lanes {100, -100, 70000, -70000}, shift=0, relu=0, width=1, Dready=1 -> Dvalid rises 2 cycles after Sready. Beats are 0x0064, 0xFF9C, 0x7FFF, 0x8000. Dlast only on the 4th beat.
- Rounding and ReLU: lanes {5, 6, -5, -6}, shift=2, width=0. relu=0 -> 1, 2, -1, -1 (Dout 0x0001, 0x0002, 0xFFFF, 0xFFFF). relu=1 -> 1, 2, 0, 0.
- Backpressure: Dready toggles 1,0,0,1,... -> Dout/Dlast held while stalled. Exactly 4 handshakes per vector, no lane duplicated or lost.
- Fill and overflow: Dready=0, 6 Sready pulses with FIFO_DEPTH=4 -> the serializer holds vector 1 and Fcount=4 after pulse 5. overflow=1 after pulse 6. Releasing Dready streams vectors 1-5 in order; vector 6 is absent.
- Full plus simultaneous pop: FIFO full and the last-lane handshake in the same cycle as Sready -> the vector is accepted, Fcount stays 4, and overflow stays 0.
- Reset mid-stream: res pulsed during lane 2 of a vector with 2 more vectors queued -> after the next posedge Dvalid=0, Fcount=0, overflow=0. No output until a new Sready, whose vector streams correctly.
